operand_packer: RTL and testbench

Producer-side front end for the operand FIFO / multiplier pipeline. It accepts a byte stream over a valid/ready handshake and packs consecutive byte pairs into 16-bit operand words {a[15:8], b[7:0]}. It writes each word into the input FIFO through that FIFO's WR/DIN/FULL write port, honouring FULL back-pressure. A trailing odd byte, marked by IN_LAST, is padded with PAD_BYTE so the multiplier still sees a full operand pair.

---
 rtl/operand_packer.sv | 95 +++++++++
 tb/tb_operand_packer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_packer.sv
// Packs a valid/ready byte stream into 16-bit operand words and writes
// them into the operand FIFO, padding an odd trailing byte.
module operand_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h01,
  parameter int         CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       IN_DATA,
  input  logic             IN_LAST,
  input  logic             FULL,
  output logic             WR,
  output logic [15:0]      DOUT,
  output logic             PADDED,
  output logic [CNT_W-1:0] WORD_CNT,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    S_HI = 2'd0,
    S_LO = 2'd1,
    S_WR = 2'd2
  } state_t;

  state_t      state, stateNxt;
  logic [7:0]  hi, hiNxt;
  logic [15:0] word, wordNxt;
  logic        pad, padNxt;
  logic        inReady, wrEn, xfer;

  always_comb begin
    stateNxt = state;
    hiNxt    = hi;
    wordNxt  = word;
    padNxt   = pad;
    inReady  = 1'b0;
    wrEn     = 1'b0;
    if (RST) begin
      inReady = (state != S_WR) || !FULL;
      wrEn    = (state == S_WR) && !FULL;
    end
    xfer = IN_VALID && inReady;

    unique case (state)
      S_LO: begin
        if (xfer) begin
          wordNxt  = {hi, IN_DATA};
          padNxt   = 1'b0;
          stateNxt = S_WR;
        end
      end
      S_WR: begin
        if (wrEn) stateNxt = S_HI;
      end
      default: ;
    endcase

    // A byte arriving while the held word drains starts the next word.
    if (xfer && state != S_LO) begin
      if (IN_LAST) begin
        wordNxt  = {IN_DATA, PAD_BYTE};
        padNxt   = 1'b1;
        stateNxt = S_WR;
      end else begin
        hiNxt    = IN_DATA;
        stateNxt = S_LO;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_HI;
      hi       <= 8'h00;
      word     <= 16'h0000;
      pad      <= 1'b0;
      WORD_CNT <= '0;
    end else begin
      state <= stateNxt;
      hi    <= hiNxt;
      word  <= wordNxt;
      pad   <= padNxt;
      if (wrEn) WORD_CNT <= WORD_CNT + 1'b1;
    end
  end

  assign IN_READY = inReady;
  assign WR       = wrEn;
  assign DOUT     = word;
  assign PADDED   = pad && wrEn;
  assign BUSY     = (state != S_HI);

endmodule

// File: tb/tb_operand_packer.sv
// Directed checks of operand_packer: three instances share one stimulus
// stream to cover the default, zero-pad and 4-bit counter variants.
module tb_operand_packer;

  logic       CLK;
  logic       RST;
  logic       inValid;
  logic [7:0] inData;
  logic       inLast;
  logic       full;

  logic        rdyA, wrA, padA, busyA;
  logic [15:0] doutA;
  logic [15:0] cntA;

  logic        rdyB, wrB, padB, busyB;
  logic [15:0] doutB;
  logic [15:0] cntB;

  logic        rdyC, wrC, padC, busyC;
  logic [15:0] doutC;
  logic [3:0]  cntC;

  int total = 0;
  int bad   = 0;

  operand_packer dutA (
    .CLK(CLK), .RST(RST),
    .IN_VALID(inValid), .IN_READY(rdyA),
    .IN_DATA(inData), .IN_LAST(inLast),
    .FULL(full), .WR(wrA), .DOUT(doutA),
    .PADDED(padA), .WORD_CNT(cntA), .BUSY(busyA)
  );

  operand_packer #(.PAD_BYTE(8'h00)) dutB (
    .CLK(CLK), .RST(RST),
    .IN_VALID(inValid), .IN_READY(rdyB),
    .IN_DATA(inData), .IN_LAST(inLast),
    .FULL(full), .WR(wrB), .DOUT(doutB),
    .PADDED(padB), .WORD_CNT(cntB), .BUSY(busyB)
  );

  operand_packer #(.CNT_W(4)) dutC (
    .CLK(CLK), .RST(RST),
    .IN_VALID(inValid), .IN_READY(rdyC),
    .IN_DATA(inData), .IN_LAST(inLast),
    .FULL(full), .WR(wrC), .DOUT(doutC),
    .PADDED(padC), .WORD_CNT(cntC), .BUSY(busyC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d,
                       input logic l, input logic f);
    inValid = v;
    inData  = d;
    inLast  = l;
    full    = f;
    #1;
  endtask

  initial begin
    RST = 1'b0;
    inValid = 1'b0; inData = 8'h00; inLast = 1'b0; full = 1'b0;

    // 1: reset
    tick();
    tick();
    drive(0, 8'h00, 0, 0);
    chk("rst_wr", wrA, 0);
    chk("rst_rdy", rdyA, 0);
    chk("rst_busy", busyA, 0);
    chk("rst_dout", doutA, 16'h0000);
    chk("rst_cnt", cntA, 0);
    RST = 1'b1;
    drive(0, 8'h00, 0, 0);
    chk("rel_rdy", rdyA, 1);
    drive(1, 8'h55, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("lo_busy", busyA, 1);
    RST = 1'b0;
    tick();
    drive(0, 8'h00, 0, 0);
    chk("mid_busy", busyA, 0);
    chk("mid_wr", wrA, 0);
    chk("mid_rdy", rdyA, 0);
    chk("mid_dout", doutA, 16'h0000);
    chk("mid_cnt", cntA, 0);
    tick();
    RST = 1'b1;
    drive(1, 8'h01, 0, 0);
    tick();
    drive(1, 8'h02, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("post_wr", wrA, 1);
    chk("post_dout", doutA, 16'h0102);
    tick();
    chk("post_wr_off", wrA, 0);
    chk("post_cnt", cntA, 1);

    // 2: single pair
    drive(1, 8'h12, 0, 0);
    tick();
    drive(1, 8'h34, 0, 0);
    chk("pair_wr_early", wrA, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("pair_wr", wrA, 1);
    chk("pair_dout", doutA, 16'h1234);
    chk("pair_pad", padA, 0);
    tick();
    chk("pair_wr_off", wrA, 0);
    chk("pair_cnt", cntA, 2);

    // 3: streaming
    drive(1, 8'h03, 0, 0);
    chk("st_rdy0", rdyA, 1);
    tick();
    drive(1, 8'h05, 0, 0);
    chk("st_rdy1", rdyA, 1);
    chk("st_wr1", wrA, 0);
    tick();
    drive(1, 8'h07, 0, 0);
    chk("st_rdy2", rdyA, 1);
    chk("st_wr2", wrA, 1);
    chk("st_dout2", doutA, 16'h0305);
    tick();
    drive(1, 8'h09, 0, 0);
    chk("st_rdy3", rdyA, 1);
    chk("st_wr3", wrA, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("st_wr4", wrA, 1);
    chk("st_dout4", doutA, 16'h0709);
    tick();
    chk("st_cnt", cntA, 4);

    // 4: odd tail, back-to-back padded words
    drive(1, 8'hAB, 1, 0);
    tick();
    drive(1, 8'hCD, 1, 0);
    chk("odd_wr", wrA, 1);
    chk("odd_dout", doutA, 16'hAB01);
    chk("odd_pad", padA, 1);
    chk("odd_dout_p0", doutB, 16'hAB00);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("odd2_wr", wrA, 1);
    chk("odd2_dout", doutA, 16'hCD01);
    chk("odd2_pad", padA, 1);
    chk("odd2_dout_p0", doutB, 16'hCD00);
    tick();
    chk("odd_wr_off", wrA, 0);
    chk("odd_pad_off", padA, 0);
    chk("odd_busy", busyA, 0);
    chk("odd_cnt", cntA, 6);

    // 5: back-pressure
    drive(1, 8'h12, 0, 0);
    tick();
    drive(1, 8'h34, 0, 0);
    tick();
    drive(1, 8'hEE, 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_wr", wrA, 0);
      chk("bp_rdy", rdyA, 0);
      chk("bp_dout", doutA, 16'h1234);
      chk("bp_busy", busyA, 1);
      tick();
    end
    chk("bp_cnt_hold", cntA, 6);
    drive(1, 8'hEE, 0, 0);
    chk("bp_rel_wr", wrA, 1);
    chk("bp_rel_rdy", rdyA, 1);
    chk("bp_rel_dout", doutA, 16'h1234);
    tick();
    drive(1, 8'hFF, 0, 0);
    chk("bp_cnt", cntA, 7);
    chk("bp_nowr", wrA, 0);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("bp_next_wr", wrA, 1);
    chk("bp_next_dout", doutA, 16'hEEFF);
    tick();
    chk("bp_cnt2", cntA, 8);

    // 6: counter wrap on the 4-bit instance
    RST = 1'b0;
    tick();
    RST = 1'b1;
    drive(0, 8'h00, 0, 0);
    chk("wrap_cnt0", cntC, 0);
    for (int n = 1; n <= 17; n++) begin
      drive(1, 8'(n), 0, 0);
      tick();
      drive(1, 8'(n + 100), 0, 0);
      tick();
      drive(0, 8'h00, 0, 0);
      tick();
      if (n == 15) chk("wrap_15", cntC, 15);
      if (n == 16) chk("wrap_16", cntC, 0);
      if (n == 17) chk("wrap_17", cntC, 1);
    end
    chk("wrap_wide", cntA, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
